shell_fire_ctrl: RTL

SHELL_FIRE_CTRL -- requirements
Module: shell_fire_ctrl

---
 rtl/shell_pkg.sv | 43 ++++
 rtl/fire_fsm.sv | 106 ++++++++++
 rtl/shell_fire_ctrl.sv | 109 ++++++++++
 3 files changed

// File: rtl/shell_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : shell_pkg
//  Desc     : Shared types and constants for the shell fire controller:
//             per-player FSM state encoding, shell-bank size, game-over code,
//             player index type and a 5-bit popcount helper.
//  Revision : 1.0 - initial release
// ============================================================================
package shell_pkg;

  // Number of shell slots per player in the shell bank
  localparam int MAX_SHELLS = 5;

  // game_state code meaning "round over / restart"
  localparam logic [1:0] GS_OVER = 2'b10;

  // Per-player fire FSM states
  typedef enum logic [2:0] {
    FS_IDLE     = 3'd0,
    FS_PEND     = 3'd1,
    FS_FIRE     = 3'd2,
    FS_COOLDOWN = 3'd3,
    FS_RELEASE  = 3'd4
  } fire_state_e;

  // Player index used by the round-robin pointer
  typedef enum logic {
    PLAYER_1 = 1'b0,
    PLAYER_2 = 1'b1
  } player_idx_e;

  // Count of free shell slots (1 = free)
  function automatic logic [2:0] popcount5(input logic [MAX_SHELLS-1:0] v);
    logic [2:0] n;
    n = 3'd0;
    for (int i = 0; i < MAX_SHELLS; i++) begin
      n = n + {2'b00, v[i]};
    end
    return n;
  endfunction

endpackage
`default_nettype wire

// File: rtl/fire_fsm.sv
`default_nettype none
// ============================================================================
//  Module   : fire_fsm
//  Desc     : One player's fire sequencer: IDLE -> PEND -> FIRE -> COOLDOWN
//             -> (RELEASE) -> IDLE, with a 24-bit cooldown counter.
//             Build option SHELL_AUTOFIRE_EN: a button still held when the
//             cooldown expires re-enters PEND (auto-repeat) instead of
//             waiting in RELEASE for the button to be let go.
//  Revision : 1.0 - initial release
// ============================================================================
module fire_fsm
  import shell_pkg::*;
#(
  parameter logic [23:0] COOLDOWN = 24'd2_500_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_game_over,
  input  logic i_btn,
  input  logic i_give,
  input  logic i_grant,
  output logic o_req,
  output logic o_fire,
  output logic o_cooling
);

  localparam logic [2:0] ST_IDLE     = FS_IDLE;
  localparam logic [2:0] ST_PEND     = FS_PEND;
  localparam logic [2:0] ST_FIRE     = FS_FIRE;
  localparam logic [2:0] ST_COOLDOWN = FS_COOLDOWN;
  localparam logic [2:0] ST_RELEASE  = FS_RELEASE;

  // Counter value on the last cooldown cycle; COOLDOWN cycles spent in COOLDOWN
  localparam logic [23:0] CNT_LAST = COOLDOWN - 24'd1;

  logic [2:0]  r_state;
  logic [2:0]  w_state_nxt;
  logic [23:0] r_cnt;
  logic        r_btn_prev;
  logic        w_btn_rise;
  logic        w_cd_done;

  assign w_btn_rise = i_btn & ~r_btn_prev;
  assign w_cd_done  = (r_cnt == CNT_LAST);

  // Next-state decode; game over overrides every other transition
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_btn_rise) w_state_nxt = ST_PEND;
      end
      ST_PEND: begin
        // Losing the shell permission drops the request without a strobe
        if (!i_give)      w_state_nxt = ST_IDLE;
        else if (i_grant) w_state_nxt = ST_FIRE;
      end
      ST_FIRE: begin
        w_state_nxt = ST_COOLDOWN;
      end
      ST_COOLDOWN: begin
        if (w_cd_done) begin
`ifdef SHELL_AUTOFIRE_EN
          w_state_nxt = i_btn ? ST_PEND : ST_IDLE;
`else
          w_state_nxt = i_btn ? ST_RELEASE : ST_IDLE;
`endif
        end
      end
      ST_RELEASE: begin
        if (!i_btn) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
    if (i_game_over) w_state_nxt = ST_IDLE;
  end

  // State register and previous-button sample for edge detection
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_btn_prev <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      // Keeps tracking during game over so a held button needs a fresh press
      r_btn_prev <= i_btn;
    end
  end

  // Cooldown counter: zero outside COOLDOWN, so it is clear on entry
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cnt <= 24'd0;
    end else if (i_game_over || (r_state != ST_COOLDOWN)) begin
      r_cnt <= 24'd0;
    end else begin
      r_cnt <= r_cnt + 24'd1;
    end
  end

  assign o_req     = (r_state == ST_PEND);
  assign o_fire    = (r_state == ST_FIRE);
  assign o_cooling = (r_state == ST_COOLDOWN);

endmodule
`default_nettype wire

// File: rtl/shell_fire_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : shell_fire_ctrl
//  Desc     : Two-player shell fire controller. Computes per-player shell
//             availability from the shell bank slot status, arbitrates the
//             single shared issue slot round-robin between the two player
//             FSMs and drives one-cycle fire strobes.
//             Build option SHELL_AUTOFIRE_EN (see fire_fsm) enables
//             auto-repeat while the fire button is held.
//  Revision : 1.0 - initial release
// ============================================================================
module shell_fire_ctrl
  import shell_pkg::*;
#(
  parameter logic [23:0] COOLDOWN     = 24'd2_500_000,
  parameter logic [2:0]  MAX_INFLIGHT = 3'd5
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] i_game_state,
  input  logic       i_btn_1,
  input  logic       i_btn_2,
  input  logic [4:0] i_valid_1_shell,
  input  logic [4:0] i_valid_2_shell,
  output logic       o_fire_1,
  output logic       o_fire_2,
  output logic       o_valid_give_shell_1,
  output logic       o_valid_give_shell_2,
  output logic       o_cooling_1,
  output logic       o_cooling_2
);

  logic        w_game_over;
  logic [1:0]  w_btn;
  logic [1:0]  w_req;
  logic [1:0]  w_pend;
  logic [1:0]  w_grant;
  logic [1:0]  w_fire;
  logic [1:0]  w_cooling;
  logic [1:0]  w_give_nxt;
  logic [1:0]  r_give;
  logic [2:0]  w_free_1;
  logic [2:0]  w_free_2;
  logic [2:0]  w_inflight_1;
  logic [2:0]  w_inflight_2;
  player_idx_e r_last;

  assign w_game_over = (i_game_state == GS_OVER);
  assign w_btn       = {i_btn_2, i_btn_1};

  // Shell availability: at least one free slot and below the in-flight cap
  assign w_free_1      = popcount5(i_valid_1_shell);
  assign w_free_2      = popcount5(i_valid_2_shell);
  assign w_inflight_1  = 3'(MAX_SHELLS) - w_free_1;
  assign w_inflight_2  = 3'(MAX_SHELLS) - w_free_2;
  assign w_give_nxt[0] = (w_free_1 != 3'd0) && (w_inflight_1 < MAX_INFLIGHT);
  assign w_give_nxt[1] = (w_free_2 != 3'd0) && (w_inflight_2 < MAX_INFLIGHT);

  // Registered shell permission, held low through reset and game over
  always_ff @(posedge clk) begin
    if (!rst_n || w_game_over) begin
      r_give <= 2'b00;
    end else begin
      r_give <= w_give_nxt;
    end
  end

  // A player competes for the issue slot only while it may take a shell
  assign w_req = w_pend & r_give;

  // Round-robin: on a tie the player that did not win the previous tie wins
  assign w_grant[0] = w_req[0] & (~w_req[1] | (r_last == PLAYER_2));
  assign w_grant[1] = w_req[1] & (~w_req[0] | (r_last == PLAYER_1));

  // Pointer moves only on contested grants; an uncontested grant (e.g. the
  // loser of a tie being served next cycle) leaves the tie order alternating
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_last <= PLAYER_2;
    end else if (!w_game_over && (&w_req)) begin
      r_last <= w_grant[0] ? PLAYER_1 : PLAYER_2;
    end
  end

  for (genvar gi = 0; gi < 2; gi++) begin : g_player
    fire_fsm #(
      .COOLDOWN (COOLDOWN)
    ) u_fire_fsm (
      .clk         (clk),
      .rst_n       (rst_n),
      .i_game_over (w_game_over),
      .i_btn       (w_btn[gi]),
      .i_give      (r_give[gi]),
      .i_grant     (w_grant[gi]),
      .o_req       (w_pend[gi]),
      .o_fire      (w_fire[gi]),
      .o_cooling   (w_cooling[gi])
    );
  end

  assign o_fire_1             = w_fire[0];
  assign o_fire_2             = w_fire[1];
  assign o_valid_give_shell_1 = r_give[0];
  assign o_valid_give_shell_2 = r_give[1];
  assign o_cooling_1          = w_cooling[0];
  assign o_cooling_2          = w_cooling[1];

endmodule
`default_nettype wire
